// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: accepts one fill command, clips it to the active VGA resolution,
// then streams one pixel write per clock in raster order (x fastest).
module vga_rect_fill #(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                vga_resolution_mode,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x0,
  input  logic [Y_W-1:0]      cmd_y0,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  input  logic                abort,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                busy,
  output logic                done,
  output logic [16:0]         pix_count
);

  localparam int unsigned XS_W  = X_W + 1;
  localparam int unsigned YS_W  = Y_W + 1;
  localparam int unsigned PIX_W = 17;

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_DRAW, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [X_W-1:0]      r_w;
  logic [Y_W-1:0]      r_h;
  logic [COLOUR_W-1:0] r_col;
  logic                r_mode;
  logic [X_W-1:0]      r_x_end;
  logic [Y_W-1:0]      r_y_end;

  // Output registers
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_we;
  logic                r_busy;
  logic                r_done;
  logic                r_ready;
  logic [PIX_W-1:0]    r_pix;

  logic [X_W-1:0]      w_x_d;
  logic [Y_W-1:0]      w_y_d;
  logic [COLOUR_W-1:0] w_colour_d;
  logic                w_we_d;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_ready_d;
  logic [PIX_W-1:0]    w_pix_d;

  // Clipping arithmetic, one bit wider than the coordinates so the sums cannot wrap
  logic [XS_W-1:0] w_xmax;
  logic [YS_W-1:0] w_ymax;
  logic [XS_W-1:0] w_x_sum;
  logic [YS_W-1:0] w_y_sum;
  logic [XS_W-1:0] w_x_lim;
  logic [YS_W-1:0] w_y_lim;
  logic [X_W-1:0]  w_x_end;
  logic [Y_W-1:0]  w_y_end;
  logic            w_empty;
  logic            w_last_col;
  logic            w_last;

  always_comb begin
    w_xmax     = r_mode ? XS_W'(320) : XS_W'(160);
    w_ymax     = r_mode ? YS_W'(240) : YS_W'(120);
    w_x_sum    = XS_W'(r_x0) + XS_W'(r_w);
    w_y_sum    = YS_W'(r_y0) + YS_W'(r_h);
    w_x_lim    = (w_x_sum < w_xmax) ? w_x_sum : w_xmax;
    w_y_lim    = (w_y_sum < w_ymax) ? w_y_sum : w_ymax;
    w_x_end    = X_W'(w_x_lim - XS_W'(1));
    w_y_end    = Y_W'(w_y_lim - YS_W'(1));
    w_empty    = (r_w == '0) || (r_h == '0) ||
                 (XS_W'(r_x0) >= w_xmax) || (YS_W'(r_y0) >= w_ymax);
    w_last_col = (r_x == r_x_end);
    w_last     = w_last_col && (r_y == r_y_end);
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nxt = S_CLIP;
      S_CLIP:  w_state_nxt = (abort || w_empty) ? S_DONE : S_DRAW;
      S_DRAW:  if (abort || w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: values the output registers take on entering the next state
  always_comb begin
    w_x_d      = r_x;
    w_y_d      = r_y;
    w_colour_d = r_colour;
    w_pix_d    = r_pix;
    w_we_d     = (w_state_nxt == S_DRAW);
    w_done_d   = (w_state_nxt == S_DONE);
    w_busy_d   = (w_state_nxt != S_IDLE);
    w_ready_d  = (w_state_nxt == S_IDLE);
    case (r_state)
      S_IDLE: if (cmd_valid) w_pix_d = '0;
      S_CLIP: begin
        if (w_state_nxt == S_DRAW) begin
          w_x_d      = r_x0;
          w_y_d      = r_y0;
          w_colour_d = r_col;
          w_pix_d    = PIX_W'(1);
        end
      end
      S_DRAW: begin
        if (w_state_nxt == S_DRAW) begin
          if (w_last_col) begin
            w_x_d = r_x0;
            w_y_d = r_y + Y_W'(1);
          end else begin
            w_x_d = r_x + X_W'(1);
          end
          w_pix_d = r_pix + PIX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_pix    <= '0;
    end else begin
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_colour <= w_colour_d;
      r_we     <= w_we_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_ready  <= w_ready_d;
      r_pix    <= w_pix_d;
    end
  end

  // Command latch and clipped end points
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_mode  <= 1'b0;
      r_x_end <= '0;
      r_y_end <= '0;
    end else begin
      if (r_state == S_IDLE && cmd_valid) begin
        r_x0   <= cmd_x0;
        r_y0   <= cmd_y0;
        r_w    <= cmd_w;
        r_h    <= cmd_h;
        r_col  <= cmd_colour;
        r_mode <= vga_resolution_mode;
      end
      if (r_state == S_CLIP) begin
        r_x_end <= w_x_end;
        r_y_end <= w_y_end;
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign colour    = r_colour;
  assign writeEn   = r_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_ready = r_ready;
  assign pix_count = r_pix;

endmodule
